// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
//   Core-side controller for a bank of N bidirectional GPIO pad cells.
//   Sequences each pin's output enable with dead-cycle turnaround,
//   synchronizes and glitch-filters the pad input, and latches edge events
//   into write-1-to-clear pending bits that are merged into one interrupt.
//
// Ports
//   clock        bank clock
//   reset_n      asynchronous active-low reset
//   cfg_dir_out  per-pin direction request (1 = output)
//   cfg_out      output data value
//   cfg_ie       input-buffer enable
//   cfg_rise_en  rising-edge capture enable
//   cfg_fall_en  falling-edge capture enable
//   clr_rise     W1C strobe for rise_pend
//   clr_fall     W1C strobe for fall_pend
//   cell_i       raw asynchronous pad input
//   cell_o       data to the pad cells (registered cfg_out)
//   cell_oe      output enable to the pad cells
//   cell_ie      input enable to the pad cells (registered cfg_ie)
//   in_val       synchronized, filtered input value
//   rise_pend    rising-edge pending bits
//   fall_pend    falling-edge pending bits
//   irq          registered OR of all pending bits
//
// Direction FSM (one per pin)
//   state     | meaning
//   ST_IN     | pad is input; glitch filter may run
//   ST_TO_OUT | dead cycles before driving; cell_oe still 0
//   ST_OUT    | pad driven while the request stays high
//   ST_TO_IN  | dead cycles after releasing the pad
module gpio_pad_ctrl #(
  parameter int N      = 8,
  parameter int FILTER = 3,
  parameter int TURN   = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] cfg_dir_out,
  input  logic [N-1:0] cfg_out,
  input  logic [N-1:0] cfg_ie,
  input  logic [N-1:0] cfg_rise_en,
  input  logic [N-1:0] cfg_fall_en,
  input  logic [N-1:0] clr_rise,
  input  logic [N-1:0] clr_fall,
  input  logic [N-1:0] cell_i,
  output logic [N-1:0] cell_o,
  output logic [N-1:0] cell_oe,
  output logic [N-1:0] cell_ie,
  output logic [N-1:0] in_val,
  output logic [N-1:0] rise_pend,
  output logic [N-1:0] fall_pend,
  output logic         irq
);

  localparam int CW = $clog2(TURN + 1);
  localparam int FW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);

  typedef enum logic [1:0] {
    ST_IN     = 2'd0,
    ST_TO_OUT = 2'd1,
    ST_OUT    = 2'd2,
    ST_TO_IN  = 2'd3
  } dir_state_t;

  logic [N-1:0] sync1, sync2;
  logic [N-1:0] oe_d;
  logic [N-1:0] in_val_d;
  logic [N-1:0] rise_set, fall_set;

  for (genvar g = 0; g < N; g++) begin : g_pin
    dir_state_t    state_q, state_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          filt_act;
    logic          iv_d;

    always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      case (state_q)
        ST_IN: begin
          if (cfg_dir_out[g]) begin
            state_d = ST_TO_OUT;
            tcnt_d  = '0;
          end
        end
        ST_TO_OUT: begin
          if (!cfg_dir_out[g]) begin
            state_d = ST_IN;
            tcnt_d  = '0;
          end else if (tcnt_q == TURN_LAST) begin
            state_d = ST_OUT;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
        ST_OUT: begin
          if (!cfg_dir_out[g]) begin
            state_d = ST_TO_IN;
            tcnt_d  = '0;
          end
        end
        ST_TO_IN: begin
          if (cfg_dir_out[g]) begin
            state_d = ST_TO_OUT;
            tcnt_d  = '0;
          end else if (tcnt_q == TURN_LAST) begin
            state_d = ST_IN;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IN;
          tcnt_d  = '0;
        end
      endcase
    end

    // Gating with the live request lets cell_oe fall on the same edge the
    // request is seen low, instead of a cycle later with the state.
    assign oe_d[g] = (state_q == ST_OUT) && cfg_dir_out[g];

    // Filter is frozen outside IN or with the input buffer off, so
    // turnaround and ie-off never fabricate edges.
    assign filt_act = (state_q == ST_IN) && cell_ie[g];

    always_comb begin
      fcnt_d = '0;
      iv_d   = in_val[g];
      if (filt_act && (sync2[g] != in_val[g])) begin
        if (fcnt_q == FILT_LAST) begin
          iv_d = sync2[g];
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
    end

    assign in_val_d[g] = iv_d;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IN;
        tcnt_q  <= '0;
        fcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        tcnt_q  <= tcnt_d;
        fcnt_q  <= fcnt_d;
      end
    end
  end

  assign rise_set = in_val_d & ~in_val & cfg_rise_en;
  assign fall_set = ~in_val_d & in_val & cfg_fall_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      cell_o    <= '0;
      cell_ie   <= '0;
      cell_oe   <= '0;
      in_val    <= '0;
      rise_pend <= '0;
      fall_pend <= '0;
      irq       <= 1'b0;
    end else begin
      sync1     <= cell_i;
      sync2     <= sync1;
      cell_o    <= cfg_out;
      cell_ie   <= cfg_ie;
      cell_oe   <= oe_d;
      in_val    <= in_val_d;
      // Set terms are OR'd last so a new event beats a same-cycle clear.
      rise_pend <= (rise_pend & ~clr_rise) | rise_set;
      fall_pend <= (fall_pend & ~clr_fall) | fall_set;
      irq       <= |(rise_pend | fall_pend);
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
module tb_gpio_pad_ctrl;

  localparam int N = 8;

  logic         clock;
  logic         reset_n;
  logic [N-1:0] cfg_dir_out, cfg_out, cfg_ie, cfg_rise_en, cfg_fall_en;
  logic [N-1:0] clr_rise, clr_fall, cell_i;
  logic [N-1:0] cell_o, cell_oe, cell_ie, in_val, rise_pend, fall_pend;
  logic         irq;

  int tests = 0;
  int fails = 0;

  gpio_pad_ctrl #(.N(N), .FILTER(3), .TURN(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_dir_out(cfg_dir_out), .cfg_out(cfg_out), .cfg_ie(cfg_ie),
    .cfg_rise_en(cfg_rise_en), .cfg_fall_en(cfg_fall_en),
    .clr_rise(clr_rise), .clr_fall(clr_fall), .cell_i(cell_i),
    .cell_o(cell_o), .cell_oe(cell_oe), .cell_ie(cell_ie), .in_val(in_val),
    .rise_pend(rise_pend), .fall_pend(fall_pend), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    cfg_dir_out = '0;
    cfg_out     = '0;
    cfg_ie      = '0;
    cfg_rise_en = '0;
    cfg_fall_en = '0;
    clr_rise    = '0;
    clr_fall    = '0;
    cell_i      = '0;
    tick(3);
    chk("rst_cell_o", 32'(cell_o), 32'h0);
    chk("rst_cell_oe", 32'(cell_oe), 32'h0);
    chk("rst_in_val", 32'(in_val), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Release; input path comes up through ie register, sync and filter.
    reset_n = 1'b1;
    tick();
    cell_i = 8'hA5;
    cfg_ie = 8'hFF;
    tick();
    chk("ie_reg", 32'(cell_ie), 32'hFF);
    tick(3);
    chk("inval_before_filter", 32'(in_val), 32'h00);
    tick();
    chk("inval_after_filter", 32'(in_val), 32'hA5);
    chk("no_pend_when_disabled", 32'(rise_pend | fall_pend), 32'h0);

    // Turnaround to output on pin 0.
    cfg_dir_out = 8'h01;
    cfg_out     = 8'h3C;
    tick();
    chk("cell_o_latency", 32'(cell_o), 32'h3C);
    tick(2);
    chk("oe_still_off", 32'(cell_oe), 32'h00);
    tick();
    chk("oe_on", 32'(cell_oe), 32'h01);
    // Filter must ignore the pad while driving.
    cell_i = 8'hA4;
    tick(5);
    chk("filter_frozen_out", 32'(in_val), 32'hA5);
    cfg_dir_out = 8'h00;
    tick();
    chk("oe_off_same_edge", 32'(cell_oe), 32'h00);
    tick(4);
    chk("filter_frozen_to_in", 32'(in_val), 32'hA5);
    tick();
    chk("filter_resumes", 32'(in_val), 32'hA4);

    // Aborted turnaround on pin 1.
    cfg_dir_out = 8'h02;
    tick();
    cfg_dir_out = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk("abort_oe_low", 32'(cell_oe), 32'h00);
      tick();
    end

    // Glitch rejection on pin 1 (also proves pin 1 is back in IN).
    cfg_rise_en = 8'h02;
    cfg_fall_en = 8'h04;
    cell_i = 8'hA6;
    tick(2);
    cell_i = 8'hA4;
    tick(6);
    chk("glitch2_inval", 32'(in_val), 32'hA4);
    chk("glitch2_pend", 32'(rise_pend), 32'h00);
    chk("glitch2_irq", 32'(irq), 32'h0);

    cell_i = 8'hA6;
    tick(3);
    cell_i = 8'hA4;
    tick();
    chk("pulse3_inval_early", 32'(in_val), 32'hA4);
    tick();
    chk("pulse3_inval", 32'(in_val), 32'hA6);
    chk("pulse3_rise_pend", 32'(rise_pend), 32'h02);
    chk("pulse3_irq_lag", 32'(irq), 32'h0);
    tick();
    chk("pulse3_irq", 32'(irq), 32'h1);
    tick(2);
    chk("pulse3_fall_back", 32'(in_val), 32'hA4);
    chk("pulse3_no_fall_pend", 32'(fall_pend), 32'h00);

    // Clear racing a new rising edge: set wins.
    cell_i = 8'hA6;
    tick(4);
    clr_rise = 8'h02;
    tick();
    clr_rise = 8'h00;
    chk("race_inval", 32'(in_val), 32'hA6);
    chk("race_set_wins", 32'(rise_pend), 32'h02);
    tick(2);
    clr_rise = 8'h02;
    tick();
    clr_rise = 8'h00;
    chk("w1c_clear", 32'(rise_pend), 32'h00);
    chk("w1c_irq_lag", 32'(irq), 32'h1);
    tick();
    chk("w1c_irq_fall", 32'(irq), 32'h0);

    // ie off on pin 2 while its pad falls: nothing may move.
    cfg_ie = 8'hFB;
    cell_i = 8'hA2;
    tick();
    chk("ie_off_reg", 32'(cell_ie), 32'hFB);
    tick(7);
    chk("ie_off_hold", 32'(in_val), 32'hA6);
    chk("ie_off_no_fall", 32'(fall_pend), 32'h00);
    cfg_ie = 8'hFF;
    tick(3);
    chk("ie_on_early", 32'(in_val), 32'hA6);
    tick();
    chk("ie_on_inval", 32'(in_val), 32'hA2);
    chk("ie_on_fall_pend", 32'(fall_pend), 32'h04);
    cfg_fall_en = 8'h00;
    tick();
    chk("disable_keeps_pend", 32'(fall_pend), 32'h04);
    chk("fall_irq", 32'(irq), 32'h1);
    clr_fall = 8'h04;
    tick();
    clr_fall = 8'h00;
    chk("fall_clear", 32'(fall_pend), 32'h00);

    // Reset mid-run with all pins driving.
    cfg_dir_out = 8'hFF;
    cfg_rise_en = 8'h01;
    tick(6);
    chk("all_oe_on", 32'(cell_oe), 32'hFF);
    reset_n = 1'b0;
    #1;
    chk("async_oe", 32'(cell_oe), 32'h00);
    chk("async_cell_o", 32'(cell_o), 32'h00);
    chk("async_cell_ie", 32'(cell_ie), 32'h00);
    chk("async_in_val", 32'(in_val), 32'h00);
    chk("async_irq", 32'(irq), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("post_rst_oe_off", 32'(cell_oe), 32'h00);
    tick();
    chk("post_rst_oe_on", 32'(cell_oe), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
